n64adv_testpattern_gen: RTL and testbench
=========================================

# n64adv_testpattern_gen

Parametrised test-pattern generator for the N64 video pipeline, the successor to the single-checkerboard generator. It is clocked at VCLK and advances only on nVDSYNC-low slots. It regenerates the incoming sync, tracks line and pixel position, and fills the active window with one of four run-time-selectable patterns: checkerboard, colour bars, grey ramp or crosshatch. It sits in the PPU ahead of the scaler/DAC path, muxed against live video.

## Interface
- COLOR_W, 7: bits per colour channel. Legal range 4..10.
- VCLK  in  1  video clock. The only clock.
- nRST  in  1  reset, asynchronous, active-low.
- nVDSYNC  in  1  data-slot strobe. All state advances only when this is low.
- vmode  in  1  0 = NTSC window, 1 = PAL window.
- pattern_sel  in  2  0 = checkerboard, 1 = colour bars, 2 = grey ramp, 3 = crosshatch.
- Sync_in  in  4  {nVSYNC, nCLAMP, nHSYNC, nCSYNC}.
- vdata_out  out  3*COLOR_W+4  {Sync[3:0], R, G, B}, registered.

## Operation
- Positive sync edges are detected against the registered output copy, not against a separate delay register:
  - posedge_nVSYNC = !vdata_out[3*COLOR_W+3] & Sync_in[3].
  - posedge_nHSYNC = !vdata_out[3*COLOR_W+1] & Sync_in[1].
- hcnt (10 b) and vcnt (9 b) counters:
  - posedge_nHSYNC clears hcnt and increments vcnt; otherwise hcnt increments.
  - Both counters saturate at all-ones.
  - posedge_nVSYNC clears vcnt and overrides a same-slot vcnt increment.
- Window constants (package):
  - NTSC: v 18..248, h 64..705.
  - PAL: v 22..296, h 72..713.
  - Comparisons are strict: inside means vstart < vcnt < vstop and hstart < hcnt < hstop.
- Window-relative coordinates:
  - x = hcnt − hstart − 1, 10 b.
  - y = vcnt − vstart − 1, 9 b.
  - Both are valid only inside the window.
- pattern_sel is latched into pat_q on posedge_nVSYNC only, so a pattern change never tears mid-frame. All pattern decoding uses pat_q.
- Patterns (inside window; outside window colour is 0):
  - 0 checkerboard: at hcnt == hstart each channel is loaded with all-vcnt[0]; at subsequent pixels each channel = all ~(previous vdata_out[0]), i.e. a one-pixel checker with line-alternating phase.
  - 1 colour bars: bar index idx (3 b) increments every BAR_W = 80 pixels, starting at 0 at x = 0 and saturating at 7. Channels are R = all ~idx[1], G = all ~idx[2], B = all ~idx[0], giving the order white, yellow, cyan, green, magenta, red, blue, black.
  - 2 grey ramp: R = G = B = x[9:10−COLOR_W].
  - 3 crosshatch: all channels all-ones when x[4:0] == 0 or y[4:0] == 0, else 0.
- The sync field of vdata_out is loaded with Sync_in on every nVDSYNC-low slot.
- When nVDSYNC is high, all registers hold.

## Timing
- Reset values: vdata_out = 0, hcnt = 0, vcnt = 0, pat_q = 0, bar counter = 0. Reset is effective immediately on nRST fall, mid-line included. The first frame after reset runs pattern 0 until the first posedge_nVSYNC.
- Latency: one nVDSYNC slot. Colour is computed from the counter values held before that slot's update, and Sync_in appears on vdata_out at the same slot edge.
- Simultaneous posedge_nVSYNC and posedge_nHSYNC: hcnt = 0, vcnt = 0, pat_q is updated.
- Bar counter: the 7-bit pixel-in-bar counter and idx are cleared whenever hcnt ≤ hstart. They advance on each in-window slot; the pixel counter wraps 79→0 and increments idx.
- vmode is used combinationally and is expected static per frame. A mid-frame change only moves the window boundaries.

## Structure
- Package n64adv_tp_pkg holds:
  - Window constants per mode.
  - BAR_W = 80, HATCH_MASK = 5'h1F.
  - Pattern enum TP_CHECK / TP_BARS / TP_RAMP / TP_HATCH.
- Sub-module n64adv_tp_barcnt contains the bar pixel counter and idx. Its inputs are clear and step enable; its output is idx.
- Top level contains the counters, edge detection, window compare and the pattern mux.

## Test plan
- Reset mid-line with nRST low for 3 VCLK: all outputs 0. After release with pattern_sel = 0 and NTSC, the first in-window line shows a checker with phase following vcnt[0].
- NTSC, pattern_sel = 1: sample at x = 0, 79, 80, 559, 560. Expect {R,G,B} = {7F,7F,7F}, {7F,7F,7F}, {7F,7F,00}, blue {00,00,7F}, black {00,00,00}. Saturation keeps the tail black through hcnt 705.
- PAL, pattern_sel = 2, COLOR_W = 7: x = 8 → 0x01, x = 639 → 0x4F. hcnt 72 and 713 → 0. vcnt 22 and 296 → 0.
- pattern_sel changed 1→3 mid-frame: bars continue until posedge_nVSYNC, then crosshatch appears. At y = 0 the whole line is all-ones; at y = 1 only x = 0, 32, 64 … are all-ones.
- Simultaneous nVSYNC/nHSYNC rise: next slot hcnt = 0, vcnt = 0. Hold nHSYNC low for 1100 slots: hcnt saturates at 1023 and output colour stays 0.
- nVDSYNC held high for 10 VCLK with toggling Sync_in: vdata_out and all counters unchanged.

Source files
------------

// File: rtl/n64adv_tp_pkg.sv
// Shared constants and types for the N64 test-pattern generator.
// Window limits are exclusive bounds on the raw line/pixel counters.
package n64adv_tp_pkg;

    localparam logic [8:0] NTSC_VSTART = 9'd18;
    localparam logic [8:0] NTSC_VSTOP  = 9'd248;
    localparam logic [9:0] NTSC_HSTART = 10'd64;
    localparam logic [9:0] NTSC_HSTOP  = 10'd705;

    localparam logic [8:0] PAL_VSTART = 9'd22;
    localparam logic [8:0] PAL_VSTOP  = 9'd296;
    localparam logic [9:0] PAL_HSTART = 10'd72;
    localparam logic [9:0] PAL_HSTOP  = 10'd713;

    localparam int unsigned BAR_W      = 80;
    localparam logic [4:0]  HATCH_MASK = 5'h1F;

    typedef enum logic [1:0] {
        TP_CHECK = 2'd0,
        TP_BARS  = 2'd1,
        TP_RAMP  = 2'd2,
        TP_HATCH = 2'd3
    } tp_pat_e;

    typedef struct packed {
        logic [8:0] vstart;
        logic [8:0] vstop;
        logic [9:0] hstart;
        logic [9:0] hstop;
    } tp_win_t;

    function automatic tp_win_t tp_window(input logic pal);
        tp_win_t w;
        if (pal) begin
            w.vstart = PAL_VSTART;
            w.vstop  = PAL_VSTOP;
            w.hstart = PAL_HSTART;
            w.hstop  = PAL_HSTOP;
        end else begin
            w.vstart = NTSC_VSTART;
            w.vstop  = NTSC_VSTOP;
            w.hstart = NTSC_HSTART;
            w.hstop  = NTSC_HSTOP;
        end
        return w;
    endfunction

endpackage

// File: rtl/n64adv_tp_barcnt.sv
// Colour-bar position: pixel-in-bar counter and saturating bar index.
module n64adv_tp_barcnt
    import n64adv_tp_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       step_i,
    output logic [2:0] idx_o
);

    logic [6:0] pix_q, pix_d;
    logic [2:0] idx_q, idx_d;

    always_comb begin
        pix_d = pix_q;
        idx_d = idx_q;
        if (clr_i) begin
            pix_d = '0;
            idx_d = '0;
        end else if (step_i) begin
            if (pix_q == 7'(BAR_W - 1)) begin
                pix_d = '0;
                // last bar (black) runs to the end of the line
                if (idx_q != 3'd7)
                    idx_d = idx_q + 3'd1;
            end else begin
                pix_d = pix_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_q <= '0;
            idx_q <= '0;
        end else begin
            pix_q <= pix_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/n64adv_testpattern_gen.sv
// Test-pattern generator: regenerates sync, tracks position and fills
// the active window with checkerboard, bars, grey ramp or crosshatch.
module n64adv_testpattern_gen
    import n64adv_tp_pkg::*;
#(
    parameter int COLOR_W = 7
) (
    input  logic                 VCLK,
    input  logic                 nRST,
    input  logic                 nVDSYNC,
    input  logic                 vmode,
    input  logic [1:0]           pattern_sel,
    input  logic [3:0]           Sync_in,
    output logic [3*COLOR_W+3:0] vdata_out
);

    localparam int VW = 3 * COLOR_W + 4;

    logic [VW-1:0] vdata_q, vdata_d;
    logic [9:0]    hcnt_q, hcnt_d;
    logic [8:0]    vcnt_q, vcnt_d;
    tp_pat_e       pat_q, pat_d;

    logic          slot;
    logic          pos_v, pos_h;
    tp_win_t       win;
    logic          v_in, h_in, in_win;
    logic [9:0]    x;
    logic [4:0]    y_lo;
    logic [2:0]    idx;
    logic [COLOR_W-1:0] r_c, g_c, b_c;

    assign slot = !nVDSYNC;

    // edges are taken against the sync copy already sitting in the output
    assign pos_v = !vdata_q[VW-1] & Sync_in[3];
    assign pos_h = !vdata_q[VW-3] & Sync_in[1];

    assign win    = tp_window(vmode);
    assign v_in   = (vcnt_q > win.vstart) && (vcnt_q < win.vstop);
    assign h_in   = (hcnt_q > win.hstart) && (hcnt_q < win.hstop);
    assign in_win = v_in && h_in;
    assign x      = hcnt_q - win.hstart - 10'd1;
    assign y_lo   = 5'(vcnt_q - win.vstart - 9'd1);

    n64adv_tp_barcnt u_barcnt (
        .clk_i  (VCLK),
        .rst_ni (nRST),
        .clr_i  (slot && (hcnt_q <= win.hstart)),
        .step_i (slot && in_win),
        .idx_o  (idx)
    );

    always_comb begin
        r_c = '0;
        g_c = '0;
        b_c = '0;
        unique case (pat_q)
            TP_CHECK: begin
                if (in_win) begin
                    r_c = {COLOR_W{~vdata_q[0]}};
                end else if (v_in && (hcnt_q == win.hstart)) begin
                    r_c = {COLOR_W{vcnt_q[0]}};
                end
                g_c = r_c;
                b_c = r_c;
            end
            TP_BARS: begin
                if (in_win) begin
                    r_c = {COLOR_W{~idx[1]}};
                    g_c = {COLOR_W{~idx[2]}};
                    b_c = {COLOR_W{~idx[0]}};
                end
            end
            TP_RAMP: begin
                if (in_win) begin
                    r_c = x[9 -: COLOR_W];
                    g_c = r_c;
                    b_c = r_c;
                end
            end
            TP_HATCH: begin
                if (in_win && (((x[4:0] & HATCH_MASK) == 5'd0) ||
                               ((y_lo & HATCH_MASK) == 5'd0))) begin
                    r_c = '1;
                    g_c = '1;
                    b_c = '1;
                end
            end
        endcase
    end

    always_comb begin
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        pat_d   = pat_q;
        vdata_d = vdata_q;
        if (slot) begin
            if (pos_h) begin
                hcnt_d = '0;
                if (vcnt_q != '1)
                    vcnt_d = vcnt_q + 9'd1;
            end else if (hcnt_q != '1) begin
                hcnt_d = hcnt_q + 10'd1;
            end
            if (pos_v) begin
                vcnt_d = '0;
                pat_d  = tp_pat_e'(pattern_sel);
            end
            vdata_d = {Sync_in, r_c, g_c, b_c};
        end
    end

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            vdata_q <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            pat_q   <= TP_CHECK;
        end else begin
            vdata_q <= vdata_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            pat_q   <= pat_d;
        end
    end

    assign vdata_out = vdata_q;

endmodule

// File: tb/tb_n64adv_testpattern_gen.sv
// Bench for n64adv_testpattern_gen: per-slot reference model, a
// table of window-position vectors and hand-written corner sequences.
module tb_n64adv_testpattern_gen;

    localparam int CW = 7;
    localparam int VW = 3 * CW + 4;
    localparam logic [CW-1:0] ONES = '1;
    localparam logic [CW-1:0] ZERO = '0;

    logic          VCLK = 1'b0;
    logic          nRST = 1'b0;
    logic          nVDSYNC = 1'b1;
    logic          vmode = 1'b0;
    logic [1:0]    pattern_sel = 2'd0;
    logic [3:0]    Sync_in = 4'hF;
    logic [VW-1:0] vdata_out;

    n64adv_testpattern_gen #(.COLOR_W(CW)) dut (
        .VCLK        (VCLK),
        .nRST        (nRST),
        .nVDSYNC     (nVDSYNC),
        .vmode       (vmode),
        .pattern_sel (pattern_sel),
        .Sync_in     (Sync_in),
        .vdata_out   (vdata_out)
    );

    always #5 VCLK = ~VCLK;

    int n_tests = 0;
    int n_fail  = 0;

    int            m_h, m_v, m_pat;
    logic [VW-1:0] m_out;
    logic          nv_lvl = 1'b1;

    typedef struct {
        logic [1:0]    pat;
        logic          pal;
        int            v;
        int            h;
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [VW-1:0] act,
                         input logic [VW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h   = 0;
        m_v   = 0;
        m_pat = 0;
        m_out = '0;
    endtask

    // Colour from the window rules, using the position before the slot
    function automatic logic [3*CW-1:0] m_colour();
        int hs, he, vs, ve, x, y, idx;
        bit vin, hin;
        logic [CW-1:0] r, g, b;
        hs = vmode ? 72 : 64;
        he = vmode ? 713 : 705;
        vs = vmode ? 22 : 18;
        ve = vmode ? 296 : 248;
        vin = (m_v > vs) && (m_v < ve);
        hin = (m_h > hs) && (m_h < he);
        x = m_h - hs - 1;
        y = m_v - vs - 1;
        r = ZERO;
        g = ZERO;
        b = ZERO;
        if (m_pat == 0) begin
            if (vin && hin) r = m_out[0] ? ZERO : ONES;
            else if (vin && m_h == hs) r = (m_v % 2 == 1) ? ONES : ZERO;
            g = r;
            b = r;
        end else if (vin && hin) begin
            case (m_pat)
                1: begin
                    idx = x / 80;
                    if (idx > 7) idx = 7;
                    r = ((idx & 2) != 0) ? ZERO : ONES;
                    g = ((idx & 4) != 0) ? ZERO : ONES;
                    b = ((idx & 1) != 0) ? ZERO : ONES;
                end
                2: begin
                    r = CW'(x >> (10 - CW));
                    g = r;
                    b = r;
                end
                default: begin
                    if ((x % 32 == 0) || (y % 32 == 0)) r = ONES;
                    g = r;
                    b = r;
                end
            endcase
        end
        return {r, g, b};
    endfunction

    task automatic model_slot();
        logic [3*CW-1:0] c;
        bit pv, ph;
        if (nVDSYNC) return;
        c  = m_colour();
        pv = !m_out[VW-1] && Sync_in[3];
        ph = !m_out[VW-3] && Sync_in[1];
        if (ph) begin
            m_h = 0;
            if (m_v < 511) m_v++;
        end else if (m_h < 1023) begin
            m_h++;
        end
        if (pv) begin
            m_v   = 0;
            m_pat = int'(pattern_sel);
        end
        m_out = {Sync_in, c};
    endtask

    function automatic logic [3:0] sy(input logic nv, input logic nh);
        return {nv, 1'b1, nh, nv & nh};
    endfunction

    task automatic slot(input logic nvd, input logic [3:0] s);
        nVDSYNC = nvd;
        Sync_in = s;
        @(posedge VCLK);
        model_slot();
        @(negedge VCLK);
        check("slot", vdata_out, m_out);
    endtask

    task automatic new_frame();
        slot(1'b0, sy(1'b0, 1'b0));
        slot(1'b0, sy(1'b1, 1'b1));
    endtask

    task automatic new_line();
        slot(1'b0, sy(nv_lvl, 1'b0));
        slot(1'b0, sy(nv_lvl, 1'b1));
    endtask

    task automatic run_px(input int n);
        repeat (n) slot(1'b0, sy(nv_lvl, 1'b1));
    endtask

    task automatic lines(input int n);
        repeat (n) new_line();
    endtask

    task automatic check_rgb(input string name, input logic [CW-1:0] r,
                             input logic [CW-1:0] g, input logic [CW-1:0] b);
        check(name, {4'h0, vdata_out[3*CW-1:0]}, {4'h0, r, g, b});
    endtask

    task automatic rslot(input logic nv, input logic nh);
        if ($urandom_range(3) == 0) slot(1'b1, 4'($urandom));
        pattern_sel = 2'($urandom);
        slot(1'b0, {nv, 1'($urandom), nh, 1'($urandom)});
    endtask

    initial begin
        int len;
        logic nvr;
        model_reset();

        vt.push_back('{2'd0, 1'b0, 20, 64, ZERO, ZERO, ZERO});
        vt.push_back('{2'd0, 1'b0, 20, 65, ONES, ONES, ONES});
        vt.push_back('{2'd0, 1'b0, 21, 64, ONES, ONES, ONES});
        vt.push_back('{2'd0, 1'b0, 21, 65, ZERO, ZERO, ZERO});
        vt.push_back('{2'd0, 1'b0, 21, 66, ONES, ONES, ONES});
        vt.push_back('{2'd0, 1'b0, 18, 65, ZERO, ZERO, ZERO});
        vt.push_back('{2'd1, 1'b0, 100, 65, ONES, ONES, ONES});
        vt.push_back('{2'd1, 1'b0, 100, 144, ONES, ONES, ONES});
        vt.push_back('{2'd1, 1'b0, 100, 145, ONES, ONES, ZERO});
        vt.push_back('{2'd1, 1'b0, 100, 225, ZERO, ONES, ONES});
        vt.push_back('{2'd1, 1'b0, 100, 305, ZERO, ONES, ZERO});
        vt.push_back('{2'd1, 1'b0, 100, 624, ZERO, ZERO, ONES});
        vt.push_back('{2'd1, 1'b0, 100, 625, ZERO, ZERO, ZERO});
        vt.push_back('{2'd1, 1'b0, 100, 704, ZERO, ZERO, ZERO});
        vt.push_back('{2'd1, 1'b0, 100, 705, ZERO, ZERO, ZERO});
        vt.push_back('{2'd2, 1'b1, 100, 81, 7'h01, 7'h01, 7'h01});
        vt.push_back('{2'd2, 1'b1, 100, 712, 7'h4F, 7'h4F, 7'h4F});
        vt.push_back('{2'd2, 1'b1, 100, 72, ZERO, ZERO, ZERO});
        vt.push_back('{2'd2, 1'b1, 100, 713, ZERO, ZERO, ZERO});
        vt.push_back('{2'd2, 1'b1, 22, 200, ZERO, ZERO, ZERO});
        vt.push_back('{2'd2, 1'b1, 296, 200, ZERO, ZERO, ZERO});
        vt.push_back('{2'd2, 1'b1, 295, 200, 7'h0F, 7'h0F, 7'h0F});
        vt.push_back('{2'd3, 1'b0, 19, 300, ONES, ONES, ONES});
        vt.push_back('{2'd3, 1'b0, 20, 65, ONES, ONES, ONES});
        vt.push_back('{2'd3, 1'b0, 20, 66, ZERO, ZERO, ZERO});
        vt.push_back('{2'd3, 1'b0, 20, 97, ONES, ONES, ONES});
        vt.push_back('{2'd3, 1'b0, 51, 100, ONES, ONES, ONES});
        vt.push_back('{2'd3, 1'b0, 52, 100, ZERO, ZERO, ZERO});

        // power-on reset
        @(negedge VCLK);
        @(negedge VCLK);
        check("reset_out", vdata_out, '0);
        nRST = 1'b1;

        foreach (vt[i]) begin
            pattern_sel = vt[i].pat;
            vmode = vt[i].pal;
            nv_lvl = 1'b1;
            new_frame();
            lines(vt[i].v);
            run_px(vt[i].h + 1);
            check_rgb($sformatf("vec%0d", i), vt[i].r, vt[i].g, vt[i].b);
        end

        // mid-line asynchronous reset; first frame stays on checkerboard
        vmode = 1'b0;
        pattern_sel = 2'd2;
        new_frame();
        lines(100);
        run_px(300);
        #2 nRST = 1'b0;
        model_reset();
        #1 check("rst_async", vdata_out, '0);
        repeat (3) @(posedge VCLK);
        @(negedge VCLK);
        check("rst_hold", vdata_out, '0);
        check("rst_hcnt", VW'(dut.hcnt_q), '0);
        nRST = 1'b1;
        nv_lvl = 1'b0;
        lines(21);
        run_px(65);
        check_rgb("rst_chk64", ONES, ONES, ONES);
        run_px(1);
        check_rgb("rst_chk65", ZERO, ZERO, ZERO);
        run_px(1);
        check_rgb("rst_chk66", ONES, ONES, ONES);
        nv_lvl = 1'b1;

        // pattern switch bars -> hatch waits for the next frame
        pattern_sel = 2'd1;
        new_frame();
        lines(100);
        run_px(146);
        check_rgb("sw_bars0", ONES, ONES, ZERO);
        pattern_sel = 2'd3;
        new_line();
        run_px(146);
        check_rgb("sw_bars1", ONES, ONES, ZERO);
        new_frame();
        lines(19);
        run_px(301);
        check_rgb("sw_hatch_y0", ONES, ONES, ONES);
        new_line();
        run_px(66);
        check_rgb("sw_hatch_x0", ONES, ONES, ONES);
        run_px(1);
        check_rgb("sw_hatch_x1", ZERO, ZERO, ZERO);
        run_px(31);
        check_rgb("sw_hatch_x32", ONES, ONES, ONES);

        // simultaneous vsync/hsync rise
        lines(5);
        run_px(10);
        new_frame();
        check("sim_hcnt", VW'(dut.hcnt_q), '0);
        check("sim_vcnt", VW'(dut.vcnt_q), '0);

        // hcnt saturation with hsync stuck low
        pattern_sel = 2'd2;
        new_frame();
        lines(100);
        repeat (1100) slot(1'b0, sy(1'b1, 1'b0));
        check("sat_hcnt", VW'(dut.hcnt_q), VW'(1023));
        check("sat_vcnt", VW'(dut.vcnt_q), VW'(100));
        check_rgb("sat_colour", ZERO, ZERO, ZERO);

        // nVDSYNC high: everything holds while Sync_in toggles
        new_frame();
        lines(50);
        run_px(200);
        repeat (10) slot(1'b1, 4'($urandom));
        check("hold_hcnt", VW'(dut.hcnt_q), VW'(m_h));
        check("hold_vcnt", VW'(dut.vcnt_q), VW'(m_v));
        check("hold_out", vdata_out, m_out);

        // randomized frames against the model
        for (int blk = 0; blk < 4; blk++) begin
            vmode = blk[0];
            rslot(1'b0, 1'b0);
            rslot(1'b1, 1'b1);
            for (int ln = 0; ln < 32; ln++) begin
                if (ln >= 17 && ln % 4 == 1) len = $urandom_range(760, 300);
                else len = $urandom_range(4, 1);
                rslot(1'b1, 1'b0);
                for (int p = 0; p < len; p++) begin
                    nvr = ($urandom_range(2999) != 0);
                    rslot(nvr, 1'b1);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
